// File: rtl/functional_unit.sv
// 32-bit execution unit: ALU, barrel shifter and multiply-add selected by a 5-bit opcode.
// Latency 1 cycle: Z/FLAGS are registered one CLOCK edge after the operands are presented.
// No backpressure: it accepts one operation every cycle and has no handshake.
//
// Ports:
//   CLOCK    rising-edge clock
//   RESET_N  asynchronous active-low reset; clears Z and FLAGS
//   A, B, C  operands (B[4:0] is the shift amount, C is the MADD/MSUB addend)
//   INST     opcode
//   CI       carry in
//   Z        registered result
//   FLAGS    registered flags {N, Zero, Carry, oVerflow}
module functional_unit (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] C,
  input  logic [4:0]  INST,
  input  logic        CI,
  output logic [31:0] Z,
  output logic [3:0]  FLAGS
);

  localparam logic [4:0] OP_ADD   = 5'd0,  OP_ADDC  = 5'd1,  OP_SUB   = 5'd2,  OP_SUBB  = 5'd3;
  localparam logic [4:0] OP_INC   = 5'd4,  OP_DEC   = 5'd5,  OP_NEG   = 5'd6,  OP_CMP   = 5'd7;
  localparam logic [4:0] OP_AND   = 5'd8,  OP_OR    = 5'd9,  OP_XOR   = 5'd10, OP_NOT   = 5'd11;
  localparam logic [4:0] OP_NAND  = 5'd12, OP_NOR   = 5'd13, OP_XNOR  = 5'd14, OP_PASSA = 5'd15;
  localparam logic [4:0] OP_SLL   = 5'd16, OP_SRL   = 5'd17, OP_SRA   = 5'd18, OP_ROL   = 5'd19;
  localparam logic [4:0] OP_ROR   = 5'd20, OP_SRC   = 5'd21, OP_MUL   = 5'd22, OP_MULHU = 5'd23;
  localparam logic [4:0] OP_MULHS = 5'd24, OP_MADD  = 5'd25, OP_MSUB  = 5'd26, OP_MINU  = 5'd27;
  localparam logic [4:0] OP_MAXU  = 5'd28, OP_SLT   = 5'd29, OP_SLTU  = 5'd30, OP_PASSB = 5'd31;

  // ---------------- add/sub: one 33-bit adder with per-opcode operand steering
  logic [31:0] add_x, add_y;
  logic        add_cin;
  logic [32:0] add_sum;
  logic        add_v;

  always_comb begin
    add_x   = A;
    add_y   = B;
    add_cin = 1'b0;
    case (INST)
      OP_ADDC:        add_cin = CI;
      OP_SUB, OP_CMP: begin add_y = ~B; add_cin = 1'b1; end
      OP_SUBB:        begin add_y = ~B; add_cin = CI;   end
      OP_INC:         begin add_y = 32'd0; add_cin = 1'b1; end
      OP_DEC:         add_y = 32'hFFFF_FFFF;
      OP_NEG:         begin add_x = ~A; add_y = 32'd0; add_cin = 1'b1; end
      default:        ;
    endcase
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};
  // Signed overflow: both addends share a sign that the sum does not.
  assign add_v   = (add_x[31] == add_y[31]) && (add_sum[31] != add_x[31]);

  // ---------------- shifter: one extra bit on the exit side captures the last bit out
  logic [4:0]  shamt;
  logic        shamt_nz;
  logic [32:0] sll_w, srl_w, sra_w;
  logic [31:0] rol_w, ror_w;

  assign shamt    = B[4:0];
  assign shamt_nz = |shamt;
  assign sll_w    = {1'b0, A} << shamt;
  assign srl_w    = {A, 1'b0} >> shamt;
  assign sra_w    = $signed({A, 1'b0}) >>> shamt;
  // A shift by 32 yields 0, so amount 0 degenerates to plain A.
  assign rol_w    = (A << shamt) | (A >> (6'd32 - {1'b0, shamt}));
  assign ror_w    = (A >> shamt) | (A << (6'd32 - {1'b0, shamt}));

  // ---------------- multiply / multiply-add: one unsigned 32x32 product
  logic [63:0] prod;
  logic [63:0] madd_w;
  logic [31:0] mulhs_hi;
  logic [31:0] msub_lo;
  logic        msub_v;

  assign prod     = {32'd0, A} * {32'd0, B};
  // A*B + C cannot exceed 2^64 - 2^32, so 64 bits hold it exactly.
  assign madd_w   = prod + {32'd0, C};
  // Signed high half from the unsigned one: subtract B when A is negative, A when B is.
  assign mulhs_hi = prod[63:32] - (A[31] ? B : 32'd0) - (B[31] ? A : 32'd0);
  assign msub_lo  = C - prod[31:0];
  assign msub_v   = prod > {32'd0, C};

  // ---------------- result select and flags
  logic [31:0] res;
  logic        c_f, v_f;
  logic [31:0] z_d, z_q;
  logic [3:0]  flags_d, flags_q;

  always_comb begin
    res = 32'd0;
    c_f = 1'b0;
    v_f = 1'b0;
    case (INST)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBB,
      OP_INC, OP_DEC, OP_NEG, OP_CMP: begin
        res = add_sum[31:0];
        c_f = add_sum[32];
        v_f = add_v;
      end
      OP_AND:   res = A & B;
      OP_OR:    res = A | B;
      OP_XOR:   res = A ^ B;
      OP_NOT:   res = ~A;
      OP_NAND:  res = ~(A & B);
      OP_NOR:   res = ~(A | B);
      OP_XNOR:  res = ~(A ^ B);
      OP_PASSA: res = A;
      OP_SLL:   begin res = sll_w[31:0]; c_f = sll_w[32]; end
      OP_SRL:   begin res = srl_w[32:1]; c_f = srl_w[0];  end
      OP_SRA:   begin res = sra_w[32:1]; c_f = sra_w[0];  end
      OP_ROL:   begin res = rol_w; c_f = shamt_nz & rol_w[0];  end
      OP_ROR:   begin res = ror_w; c_f = shamt_nz & ror_w[31]; end
      OP_SRC:   begin res = {CI, A[31:1]}; c_f = A[0]; end
      OP_MUL:   begin res = prod[31:0]; v_f = |prod[63:32]; end
      OP_MULHU: res = prod[63:32];
      OP_MULHS: res = mulhs_hi;
      OP_MADD:  begin res = madd_w[31:0]; v_f = |madd_w[63:32]; end
      OP_MSUB:  begin res = msub_lo; v_f = (|prod[63:32]) | msub_v; end
      OP_MINU:  res = (A < B) ? A : B;
      OP_MAXU:  res = (A < B) ? B : A;
      OP_SLT:   res = {31'd0, $signed(A) < $signed(B)};
      OP_SLTU:  res = {31'd0, A < B};
      OP_PASSB: res = B;
      default:  ;
    endcase
    z_d     = res;
    flags_d = {res[31], res == 32'd0, c_f, v_f};
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      z_q     <= 32'd0;
      flags_q <= 4'd0;
    end else begin
      z_q     <= z_d;
      flags_q <= flags_d;
    end
  end

  assign Z     = z_q;
  assign FLAGS = flags_q;

endmodule

// File: tb/tb_functional_unit.sv
module tb_functional_unit;

  logic        CLOCK = 1'b0;
  logic        RESET_N;
  logic [31:0] A, B, C;
  logic [4:0]  INST;
  logic        CI;
  logic [31:0] Z;
  logic [3:0]  FLAGS;

  functional_unit dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .A(A), .B(B), .C(C),
    .INST(INST), .CI(CI), .Z(Z), .FLAGS(FLAGS)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [31:0] a, b, c;
    logic [4:0]  inst;
    logic        ci;
    logic [31:0] z;
    logic [3:0]  f;
    string       name;
  } vec_t;

  vec_t vt[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  task automatic addv(input string nm, input logic [4:0] op, input logic [31:0] a, b, c,
                      input logic ci, input logic [31:0] z, input logic [3:0] f);
    vec_t v;
    v.name = nm; v.inst = op; v.a = a; v.b = b; v.c = c; v.ci = ci; v.z = z; v.f = f;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, b, c, input logic ci);
    INST = op; A = a; B = b; C = c; CI = ci;
  endtask

  function automatic logic ovf(input longint x);
    return (x > MAXI) || (x < MINI);
  endfunction

  // Reference model built from 64-bit arithmetic and bit-by-bit shifting.
  function automatic void model(input logic [31:0] a, b, c, input logic [4:0] op, input logic ci,
                                output logic [31:0] z, output logic [3:0] f);
    longint unsigned ua, ub, uc, nb, lci, t, p;
    longint          sa, sb, sci, ps;
    logic            cf, vf;
    logic [31:0]     r;
    ua = {32'd0, a}; ub = {32'd0, b}; uc = {32'd0, c}; nb = {32'd0, ~b}; lci = {63'd0, ci};
    sa = longint'($signed(a)); sb = longint'($signed(b)); sci = longint'(lci);
    p  = ua * ub;
    ps = sa * sb;
    cf = 1'b0; vf = 1'b0; z = 32'd0; t = 64'd0;
    case (op)
      5'd0: begin t = ua + ub;           vf = ovf(sa + sb); end
      5'd1: begin t = ua + ub + lci;     vf = ovf(sa + sb + sci); end
      5'd2, 5'd7: begin t = ua + nb + 1; vf = ovf(sa - sb); end
      5'd3: begin t = ua + nb + lci;     vf = ovf(sa - sb - 1 + sci); end
      5'd4: begin t = ua + 1;            vf = ovf(sa + 1); end
      5'd5: begin t = ua + 64'hFFFF_FFFF; vf = ovf(sa - 1); end
      5'd6: begin t = {32'd0, ~a} + 1;   vf = ovf(-sa); end
      default: ;
    endcase
    if (op <= 5'd7) begin z = t[31:0]; cf = t[32]; end
    r = a;
    case (op)
      5'd8:  z = a & b;
      5'd9:  z = a | b;
      5'd10: z = a ^ b;
      5'd11: z = ~a;
      5'd12: z = ~(a & b);
      5'd13: z = ~(a | b);
      5'd14: z = ~(a ^ b);
      5'd15: z = a;
      5'd16, 5'd17, 5'd18, 5'd19, 5'd20: begin
        for (int i = 0; i < int'(b[4:0]); i++) begin
          case (op)
            5'd16: begin cf = r[31]; r = r << 1; end
            5'd17: begin cf = r[0];  r = r >> 1; end
            5'd18: begin cf = r[0];  r = {r[31], r[31:1]}; end
            5'd19: begin r = {r[30:0], r[31]}; cf = r[0]; end
            default: begin r = {r[0], r[31:1]}; cf = r[31]; end
          endcase
        end
        z = r;
      end
      5'd21: begin z = {ci, a[31:1]}; cf = a[0]; end
      5'd22: begin z = p[31:0]; vf = (p[63:32] != 0); end
      5'd23: z = p[63:32];
      5'd24: z = ps[63:32];
      5'd25: begin t = p + uc; z = t[31:0]; vf = (t[63:32] != 0); end
      5'd26: begin z = c - p[31:0]; vf = (p > uc); end
      5'd27: z = (ua < ub) ? a : b;
      5'd28: z = (ua > ub) ? a : b;
      5'd29: z = (sa < sb) ? 32'd1 : 32'd0;
      5'd30: z = (ua < ub) ? 32'd1 : 32'd0;
      5'd31: z = b;
      default: ;
    endcase
    f = {z[31], z == 32'd0, cf, vf};
  endfunction

  initial begin
    logic [31:0] ez;
    logic [3:0]  ef;

    //     name          op     A             B             C            CI    Z             FLAGS
    addv("add_ovf",     5'd0,  32'h7FFFFFFF, 32'h1,        32'h0,       1'b0, 32'h80000000, 4'h9);
    addv("add_wrap",    5'd0,  32'hFFFFFFFF, 32'h1,        32'h0,       1'b0, 32'h0,        4'h6);
    addv("sub_eq",      5'd2,  32'h5,        32'h5,        32'h0,       1'b0, 32'h0,        4'h6);
    addv("cmp_lt",      5'd7,  32'h3,        32'h5,        32'h0,       1'b0, 32'hFFFFFFFE, 4'h8);
    addv("sll_carry",   5'd16, 32'h80000001, 32'h1,        32'h0,       1'b0, 32'h2,        4'h2);
    addv("sra_31",      5'd18, 32'h80000000, 32'd31,       32'h0,       1'b0, 32'hFFFFFFFF, 4'h8);
    addv("madd_ovf",    5'd25, 32'h10000,    32'h10000,    32'h5,       1'b0, 32'h5,        4'h1);
    addv("mulhs_neg",   5'd24, 32'hFFFFFFFF, 32'h2,        32'h0,       1'b0, 32'hFFFFFFFF, 4'h8);
    addv("addc_ci",     5'd1,  32'h1,        32'h1,        32'h0,       1'b1, 32'h3,        4'h0);
    addv("subb_ci0",    5'd3,  32'h5,        32'h3,        32'h0,       1'b0, 32'h1,        4'h2);
    addv("neg_zero",    5'd6,  32'h0,        32'h0,        32'h0,       1'b0, 32'h0,        4'h6);
    addv("neg_min",     5'd6,  32'h80000000, 32'h0,        32'h0,       1'b0, 32'h80000000, 4'h9);
    addv("dec_zero",    5'd5,  32'h0,        32'h0,        32'h0,       1'b0, 32'hFFFFFFFF, 4'h8);
    addv("inc_ovf",     5'd4,  32'h7FFFFFFF, 32'h0,        32'h0,       1'b0, 32'h80000000, 4'h9);
    addv("xnor_eq",     5'd14, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0,       1'b0, 32'hFFFFFFFF, 4'h8);
    addv("and_zero",    5'd8,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0,       1'b0, 32'h0,        4'h4);
    addv("srl_amt0",    5'd17, 32'h1,        32'h0,        32'h0,       1'b0, 32'h1,        4'h0);
    addv("srl_carry",   5'd17, 32'h3,        32'h1,        32'h0,       1'b0, 32'h1,        4'h2);
    addv("sll_amt0",    5'd16, 32'h1,        32'h20,       32'h0,       1'b0, 32'h1,        4'h0);
    addv("sll_31",      5'd16, 32'h1,        32'd31,       32'h0,       1'b0, 32'h80000000, 4'h8);
    addv("sra_4",       5'd18, 32'h80000000, 32'd4,        32'h0,       1'b0, 32'hF8000000, 4'h8);
    addv("rol_1",       5'd19, 32'h80000000, 32'h1,        32'h0,       1'b0, 32'h1,        4'h2);
    addv("ror_1",       5'd20, 32'h1,        32'h1,        32'h0,       1'b0, 32'h80000000, 4'hA);
    addv("ror_amt0",    5'd20, 32'h80000000, 32'h0,        32'h0,       1'b0, 32'h80000000, 4'h8);
    addv("src_ci",      5'd21, 32'h3,        32'h0,        32'h0,       1'b1, 32'h80000001, 4'hA);
    addv("mul_ovf",     5'd22, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,       1'b0, 32'h1,        4'h1);
    addv("mulhu_max",   5'd23, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,       1'b0, 32'hFFFFFFFE, 4'h8);
    addv("msub_fit",    5'd26, 32'h2,        32'h3,        32'd10,      1'b0, 32'h4,        4'h0);
    addv("msub_under",  5'd26, 32'h2,        32'h3,        32'd5,       1'b0, 32'hFFFFFFFF, 4'h9);
    addv("slt_signed",  5'd29, 32'hFFFFFFFF, 32'h1,        32'h0,       1'b0, 32'h1,        4'h0);
    addv("sltu_big",    5'd30, 32'hFFFFFFFF, 32'h1,        32'h0,       1'b0, 32'h0,        4'h4);
    addv("minu",        5'd27, 32'h5,        32'hFFFFFFFF, 32'h0,       1'b0, 32'h5,        4'h0);
    addv("maxu",        5'd28, 32'h5,        32'hFFFFFFFF, 32'h0,       1'b0, 32'hFFFFFFFF, 4'h8);
    addv("passa",       5'd15, 32'h80000000, 32'h1,        32'h0,       1'b0, 32'h80000000, 4'h8);
    addv("passb_zero",  5'd31, 32'h12345678, 32'h0,        32'h0,       1'b0, 32'h0,        4'h4);

    RESET_N = 1'b0;
    drive(5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge CLOCK);
    #1;
    chk("reset_z", Z, 32'h0);
    chk("reset_flags", {28'd0, FLAGS}, 32'h0);
    RESET_N = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].inst, vt[i].a, vt[i].b, vt[i].c, vt[i].ci);
      @(posedge CLOCK);
      #1;
      chk({vt[i].name, "_z"}, Z, vt[i].z);
      chk({vt[i].name, "_flags"}, {28'd0, FLAGS}, {28'd0, vt[i].f});
    end

    // Reset asserted mid-stream clears outputs without a clock edge.
    drive(5'd0, 32'd5, 32'd6, 32'd0, 1'b0);
    @(posedge CLOCK);
    #1;
    chk("pre_reset_z", Z, 32'd11);
    drive(5'd0, 32'hFFFFFFFF, 32'h1, 32'd0, 1'b0);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("midreset_z", Z, 32'h0);
    chk("midreset_flags", {28'd0, FLAGS}, 32'h0);
    @(posedge CLOCK);
    #1;
    chk("held_reset_z", Z, 32'h0);
    chk("held_reset_flags", {28'd0, FLAGS}, 32'h0);
    drive(5'd0, 32'd1, 32'd2, 32'd0, 1'b0);
    RESET_N = 1'b1;
    @(posedge CLOCK);
    #1;
    chk("post_reset_add_z", Z, 32'd3);
    chk("post_reset_add_flags", {28'd0, FLAGS}, 32'h0);

    // Back-to-back stream, opcode incrementing every cycle.
    for (int round = 0; round < 3; round++) begin
      for (int op = 0; op < 32; op++) begin
        logic [31:0] ra, rb, rc;
        logic        rci;
        ra  = $urandom;
        rb  = (round == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        rc  = (round == 2) ? 32'($urandom_range(0, 3)) : $urandom;
        rci = 1'($urandom_range(0, 1));
        drive(5'(op), ra, rb, rc, rci);
        model(ra, rb, rc, 5'(op), rci, ez, ef);
        @(posedge CLOCK);
        #1;
        n_tests++;
        if ($isunknown({Z, FLAGS})) begin
          n_fail++;
          $display("FAIL stream_x op=%0d: got Z=%h FLAGS=%b, required no X", op, Z, FLAGS);
        end
        chk($sformatf("stream_r%0d_op%0d_z", round, op), Z, ez);
        chk($sformatf("stream_r%0d_op%0d_flags", round, op), {28'd0, FLAGS}, {28'd0, ef});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
